// File: rtl/cpu_nios_oci_dct_pkg.sv
// Shared constants, state encoding and word packing for the OCI compressed-trace (DCT) path.
package cpu_nios_oci_dct_pkg;

  localparam int ATOM_W     = 2;
  localparam int SLOTS      = 15;
  localparam int CNT_W      = 4;
  localparam int BUF_W      = ATOM_W * SLOTS;
  localparam int DCT_WORD_W = CNT_W + BUF_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } dct_state_e;

  function automatic logic [DCT_WORD_W-1:0] pack_word(input logic [CNT_W-1:0] count,
                                                      input logic [BUF_W-1:0] buffer);
    return {count, buffer};
  endfunction

  function automatic dct_state_e state_of(input logic [CNT_W-1:0] count);
    if (count == '0) return EMPTY;
    if (count == CNT_W'(SLOTS)) return FULL;
    return FILL;
  endfunction

endpackage

// File: rtl/cpu_nios_oci_dct_out_reg.sv
// Single-entry valid/ready holding register for emitted DCT words.
module cpu_nios_oci_dct_out_reg
  import cpu_nios_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DCT_WORD_W-1:0] load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DCT_WORD_W-1:0] out_data,
  output logic                  out_free
);

  assign out_free = !out_valid || out_ready;

  // load is only asserted when out_free, so a held word is never overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_nios_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot DCT words and hands them to the trace store over valid/ready.
//   state | meaning
//   EMPTY | count == 0, nothing to emit
//   FILL  | count 1..14, emits only on pending flush
//   FULL  | count == 15, emits as soon as the output register is free
module cpu_nios_cpu_oci_dct_packer
  import cpu_nios_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_enable,
  input  logic                  atom_valid,
  input  logic [ATOM_W-1:0]     atom,
  input  logic                  flush,
  input  logic                  overflow_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DCT_WORD_W-1:0] out_data,
  output logic [BUF_W-1:0]      dct_buffer,
  output logic [CNT_W-1:0]      dct_count,
  output logic                  overflow
);

  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic             accept, out_free, xfer, drop;
  dct_state_e       state;

  assign accept = atom_valid && trace_enable;
  assign state  = state_of(count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      buffer_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      buffer_q  <= buffer_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    buffer_d  = buffer_q;
    count_d   = count_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    xfer      = 1'b0;
    drop      = 1'b0;

    case (state)
      EMPTY:   xfer = 1'b0;
      FILL:    xfer = out_free && pending_q;
      FULL:    xfer = out_free;
      default: xfer = 1'b0;
    endcase

    if (xfer) begin
      buffer_d = '0;
      count_d  = '0;
    end

    // an atom arriving with a transfer lands in the freshly cleared buffer
    if (accept) begin
      if (state == FULL && !xfer) begin
        drop = 1'b1;
      end else begin
        buffer_d = {buffer_d[BUF_W-ATOM_W-1:0], atom};
        count_d  = count_d + CNT_W'(1);
      end
    end

    // a flush coinciding with a transfer only needs to cover the atom packed after it
    if (xfer) begin
      pending_d = flush && accept;
    end else if (flush && (state != EMPTY || accept)) begin
      pending_d = 1'b1;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clear) begin
      ovf_d = 1'b0;
    end
  end

  cpu_nios_oci_dct_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .load_data (pack_word(count_q, buffer_q)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_free  (out_free)
  );

  assign dct_buffer = buffer_q;
  assign dct_count  = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cpu_nios_cpu_oci_dct_packer.sv
// Self-checking bench: directed literal cases plus randomized traffic against a queue-based model.
module tb_cpu_nios_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        overflow_clear;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 0;

  cpu_nios_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .trace_enable   (trace_enable),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .flush          (flush),
    .overflow_clear (overflow_clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // oldest atom sits in the most significant filled slot
  function automatic logic [29:0] pack_q(input logic [1:0] qq[$]);
    logic [29:0] v;
    int n;
    v = '0;
    n = qq.size();
    for (int i = 0; i < n; i++) v = v | (30'(qq[i]) << (2 * (n - 1 - i)));
    return v;
  endfunction

  // model: atoms waiting in the buffer, atoms not yet delivered, and the held output word
  logic [1:0]  mq[$];
  logic [1:0]  stream[$];
  logic        m_valid = 1'b0;
  logic [33:0] m_data = '0;
  bit          m_pend = 0;
  bit          m_ovf = 0;

  always @(posedge clk) begin : model
    bit acc, free, xfer, drop;
    int n;
    if (reset) begin
      mq.delete();
      stream.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_pend  = 0;
      m_ovf   = 0;
    end else begin
      n    = mq.size();
      acc  = atom_valid && trace_enable;
      free = !m_valid || out_ready;
      xfer = free && (n == 15 || (m_pend && n != 0));
      drop = 0;
      if (xfer) begin
        m_data  = {4'(n), pack_q(mq)};
        m_valid = 1'b1;
        mq.delete();
        m_pend  = flush && acc;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (flush && (n != 0 || acc)) m_pend = 1;
      end
      if (acc) begin
        if (mq.size() < 15) begin
          mq.push_back(atom);
          stream.push_back(atom);
        end else begin
          drop  = 1;
          m_ovf = 1;
        end
      end
      if (!drop && overflow_clear) m_ovf = 0;
    end
  end

  always @(negedge clk) begin : compare
    int n;
    if (check_en) begin
      check("count", dct_count, mq.size());
      check("buffer", dct_buffer, pack_q(mq));
      check("valid", out_valid, m_valid);
      if (m_valid) check("data", out_data, m_data);
      check("overflow", overflow, m_ovf);
      // delivered word must carry the next undelivered atoms in order
      if (out_valid && out_ready && !reset) begin
        n = int'(out_data[33:30]);
        for (int k = n - 1; k >= 0; k--) begin
          if (stream.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL order_underrun: word atom %0h with no atom outstanding", out_data[2*k +: 2]);
          end else begin
            check("order_atom", out_data[2*k +: 2], stream[0]);
            void'(stream.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [33:0] w_full;
    int ready_pct;
    w_full = {4'hF, 30'h1555_5555};

    reset = 1; trace_enable = 1; atom_valid = 0; atom = 0;
    flush = 0; overflow_clear = 0; out_ready = 1;
    repeat (3) cyc();
    reset = 0;
    check_en = 1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_buffer", dct_buffer, 0);
    check("rst_count", dct_count, 0);
    check("rst_overflow", overflow, 0);

    // 15 x 2'b01 -> full word one cycle after count hits 15
    for (int i = 0; i < 15; i++) begin atom_valid = 1; atom = 2'b01; cyc(); end
    atom_valid = 0;
    check("full_count", dct_count, 15);
    check("full_not_yet", out_valid, 0);
    cyc();
    check("full_valid", out_valid, 1);
    check("full_word", out_data, w_full);
    check("full_count_clr", dct_count, 0);
    cyc();
    check("full_consumed", out_valid, 0);

    // 11,10,01 then flush
    atom_valid = 1; atom = 2'b11; cyc();
    atom = 2'b10; cyc();
    atom = 2'b01; cyc();
    atom_valid = 0; flush = 1; cyc();
    flush = 0;
    check("flush_wait", out_valid, 0);
    cyc();
    check("flush_valid", out_valid, 1);
    check("flush_word", out_data, {4'd3, 24'b0, 6'b111001});
    check("flush_count", dct_count, 0);
    cyc();

    // flush on empty buffer is a no-op
    flush = 1; cyc();
    flush = 0;
    check("flush_empty_v0", out_valid, 0);
    cyc();
    check("flush_empty_v1", out_valid, 0);
    check("flush_empty_cnt", dct_count, 0);

    // flush together with an atom from empty
    flush = 1; atom_valid = 1; atom = 2'b10; cyc();
    flush = 0; atom_valid = 0;
    check("flush_atom_cnt", dct_count, 1);
    cyc();
    check("flush_atom_valid", out_valid, 1);
    check("flush_atom_word", out_data, {4'd1, 28'd0, 2'b10});
    cyc();

    // back-pressure: 31 atoms, last one dropped
    out_ready = 0;
    for (int i = 0; i < 31; i++) begin atom_valid = 1; atom = 2'($urandom); cyc(); end
    atom_valid = 0;
    check("bp_count", dct_count, 15);
    check("bp_valid", out_valid, 1);
    check("bp_word_cnt", out_data[33:30], 15);
    check("bp_overflow", overflow, 1);
    cyc();
    check("bp_hold", out_valid, 1);
    out_ready = 1; cyc();
    check("bp_word2_valid", out_valid, 1);
    check("bp_word2_cnt", out_data[33:30], 15);
    check("bp_buf_empty", dct_count, 0);
    check("bp_ovf_sticky", overflow, 1);
    cyc();
    check("bp_drained", out_valid, 0);
    check("bp_ovf_sticky2", overflow, 1);
    overflow_clear = 1; cyc();
    overflow_clear = 0;
    check("bp_ovf_clear", overflow, 0);

    // 16 consecutive atoms, no stall
    for (int i = 0; i < 16; i++) begin atom_valid = 1; atom = 2'($urandom); cyc(); end
    atom_valid = 0;
    check("seq16_count", dct_count, 1);
    check("seq16_valid", out_valid, 1);
    check("seq16_word_cnt", out_data[33:30], 15);
    flush = 1; cyc();
    flush = 0; cyc();
    cyc();

    // reset with a held word and a partial buffer
    out_ready = 0;
    for (int i = 0; i < 22; i++) begin atom_valid = 1; atom = 2'($urandom); cyc(); end
    atom_valid = 0;
    check("pre_rst_count", dct_count, 7);
    check("pre_rst_valid", out_valid, 1);
    reset = 1; cyc();
    reset = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_buffer", dct_buffer, 0);
    check("mid_rst_count", dct_count, 0);
    check("mid_rst_ovf", overflow, 0);
    out_ready = 1; cyc();
    check("mid_rst_no_word", out_valid, 0);

    // randomized traffic with varying back-pressure
    ready_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) ready_pct = $urandom_range(10, 100);
      atom_valid     = ($urandom_range(0, 3) != 0);
      atom           = 2'($urandom);
      trace_enable   = ($urandom_range(0, 9) != 0);
      flush          = ($urandom_range(0, 11) == 0);
      out_ready      = ($urandom_range(1, 100) <= ready_pct);
      overflow_clear = ($urandom_range(0, 29) == 0);
      reset          = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset = 0; atom_valid = 0; flush = 0; overflow_clear = 0; out_ready = 1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
